program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
16-bit 6502 program counter that sits directly downstream of the 8-bit general register. It consumes that register's data_out to load the PC low and high bytes and to apply signed relative branch offsets. It increments after opcode and operand fetches, and adds the extra fixup cycle when a branch crosses a page boundary. pc_out drives the address mux, and busy stalls the sequencer during fixup.

Parameters:
RESET_VALUE, 16'h0000, PC value after synchronous reset; the reset-vector fetch is done by the sequencer, not here.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces PC to RESET_VALUE
data_in  input  8  byte from the general register data_out: address byte or signed branch offset
load_lo  input  1  pc_lo <= data_in
load_hi  input  1  pc_hi <= data_in
inc  input  1  16-bit increment of PC
branch  input  1  add sign-extended data_in to PC, 6502 relative-branch timing
pc_out  output  16  current PC {pc_hi, pc_lo}
busy  output  1  high while in FIXUP; commands ignored
page_cross  output  1  one-cycle pulse, high during the FIXUP cycle

Behaviour:
- Reset (sync, highest priority, valid in any state):
  - pc_hi/pc_lo <= RESET_VALUE; state <= IDLE.
  - busy = 0, page_cross = 0.
  - Reset during FIXUP abandons the fixup.
- States: IDLE, FIXUP. busy = (state == FIXUP); page_cross = (state == FIXUP).
- IDLE command priority: load_lo/load_hi > branch > inc. Lower-priority commands asserted in the same cycle are dropped.
  - load_lo and load_hi together: both bytes <= data_in in the same cycle.
  - Either load alone: updates only its byte; the other byte holds.
  - inc: PC <= PC + 1 modulo 2^16. Carry into pc_hi happens the same cycle, no extra cycle. 16'hFFFF -> 16'h0000.
  - branch (1-cycle add on low byte):
    - s = {1'b0, pc_lo} + {1'b0, data_in} (9-bit); pc_lo <= s[7:0].
    - Crossing, positive offset (data_in[7]=0) with s[8]=1: FIXUP with dir=+1.
    - Crossing, negative offset (data_in[7]=1) with s[8]=0: FIXUP with dir=-1.
    - Otherwise: stay IDLE, branch complete in 1 cycle, pc_hi unchanged.
    - dir is latched in a 1-bit register.
- FIXUP (exactly one cycle):
  - pc_hi <= pc_hi + 1 (dir=+1) or pc_hi - 1 (dir=-1), modulo 256; then IDLE.
  - Wrap: 8'hFF+1 = 8'h00, 8'h00-1 = 8'hFF.
  - All commands (load_lo, load_hi, inc, branch) are ignored; the sequencer must hold them.
  - pc_out shows the intermediate value {old pc_hi, new pc_lo} during FIXUP. This is 6502-accurate; the dummy read uses it.
- No command in IDLE: PC holds.
- Latency: each command's result is visible on pc_out the cycle after the edge it is sampled on. Branch with page cross completes 2 cycles after sampling.
- pc_out is purely registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with RESET_VALUE=16'h0000, then load_lo with data_in=8'h34, then load_hi with 8'h12 -> pc_out 16'h0034, then 16'h1234; busy and page_cross stay 0.
- PC=16'h12FF, inc for one cycle -> 16'h1300 the next cycle. PC=16'hFFFF, inc -> 16'h0000. inc+load_lo together with data_in=8'hAA at 16'h1234 -> 16'h12AA (load wins).
- PC=16'h1234, branch with data_in=8'h10 -> 16'h1244 next cycle; busy never asserts. PC=16'h1234, branch 8'hF0 (-16) -> 16'h1224, no fixup.
- PC=16'h12F0, branch with data_in=8'h7F:
  - cycle+1: pc_out=16'h126F, busy=1, page_cross=1; inc asserted this cycle is ignored.
  - cycle+2: pc_out=16'h136F, busy=0.
- PC=16'h1205, branch with 8'hF0 -> 16'h12F5 with busy=1, then 16'h11F5. PC=16'hFFF0, branch 8'h20 -> 16'hFF10, then 16'h0010.
- Reset asserted during FIXUP (from PC=16'h12F0 with branch 8'h7F) -> next cycle pc_out=RESET_VALUE, busy=0, page_cross=0; a subsequent inc gives 16'h0001.

Source files
------------

// File: rtl/program_counter.sv
// 16-bit 6502 program counter.
// Loads address bytes from the general register, increments after fetches,
// and applies signed relative branches with the extra page-cross fixup cycle.
module program_counter #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic        inc,
    input  logic        branch,
    output logic [15:0] pc_out,
    output logic        busy,
    output logic        page_cross
);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_FIXUP = 1'b1;

    // dir_q: 0 = high byte +1, 1 = high byte -1
    logic        state_q, state_d;
    logic        dir_q, dir_d;
    logic [7:0]  pc_lo_q, pc_lo_d;
    logic [7:0]  pc_hi_q, pc_hi_d;
    logic [8:0]  lo_sum;
    logic [15:0] pc_plus_one;

    assign lo_sum      = {1'b0, pc_lo_q} + {1'b0, data_in};
    assign pc_plus_one = {pc_hi_q, pc_lo_q} + 16'd1;

    // Next-state: command decode in IDLE, high-byte adjust in FIXUP
    always_comb begin
        state_d = STATE_IDLE;
        dir_d   = dir_q;
        pc_lo_d = pc_lo_q;
        pc_hi_d = pc_hi_q;
        case (state_q)
            STATE_IDLE: begin
                if (load_lo || load_hi) begin
                    if (load_lo) pc_lo_d = data_in;
                    if (load_hi) pc_hi_d = data_in;
                end else if (branch) begin
                    pc_lo_d = lo_sum[7:0];
                    // Carry out on a forward offset, or no carry on a backward one,
                    // means the target lies in the neighbouring page.
                    if (!data_in[7] && lo_sum[8]) begin
                        state_d = STATE_FIXUP;
                        dir_d   = 1'b0;
                    end else if (data_in[7] && !lo_sum[8]) begin
                        state_d = STATE_FIXUP;
                        dir_d   = 1'b1;
                    end
                end else if (inc) begin
                    {pc_hi_d, pc_lo_d} = pc_plus_one;
                end
            end
            STATE_FIXUP: begin
                // Commands are ignored here; the sequencer holds them.
                pc_hi_d = dir_q ? (pc_hi_q - 8'd1) : (pc_hi_q + 8'd1);
                state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            dir_q   <= 1'b0;
            pc_lo_q <= RESET_VALUE[7:0];
            pc_hi_q <= RESET_VALUE[15:8];
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pc_lo_q <= pc_lo_d;
            pc_hi_q <= pc_hi_d;
        end
    end

    assign pc_out     = {pc_hi_q, pc_lo_q};
    assign busy       = (state_q == STATE_FIXUP);
    assign page_cross = (state_q == STATE_FIXUP);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases plus random commands
// compared against a 16-bit arithmetic reference model.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        load_lo;
    logic        load_hi;
    logic        inc;
    logic        branch;
    logic [15:0] pc_out;
    logic        busy;
    logic        page_cross;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: full PC, plus pending branch target while fixing up
    logic [15:0] m_pc;
    logic [15:0] m_target;
    logic        m_fix;

    program_counter #(
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_lo    (load_lo),
        .load_hi    (load_hi),
        .inc        (inc),
        .branch     (branch),
        .pc_out     (pc_out),
        .busy       (busy),
        .page_cross (page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock with the given inputs
    task automatic model_step(input logic r, input logic [7:0] d, input logic ll,
                              input logic lh, input logic in, input logic br);
        logic [15:0] t;
        if (r) begin
            m_pc  = 16'h0000;
            m_fix = 1'b0;
        end else if (m_fix) begin
            m_pc  = m_target;
            m_fix = 1'b0;
        end else if (ll || lh) begin
            if (ll) m_pc[7:0]  = d;
            if (lh) m_pc[15:8] = d;
        end else if (br) begin
            t = m_pc + {{8{d[7]}}, d};
            if (t[15:8] != m_pc[15:8]) begin
                m_target = t;
                m_pc     = {m_pc[15:8], t[7:0]};
                m_fix    = 1'b1;
            end else begin
                m_pc = t;
            end
        end else if (in) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    // Drive one cycle, step the model, then compare just after the edge
    task automatic do_cycle(input logic r, input logic [7:0] d, input logic ll,
                            input logic lh, input logic in, input logic br);
        reset   = r;
        data_in = d;
        load_lo = ll;
        load_hi = lh;
        inc     = in;
        branch  = br;
        @(posedge clk);
        model_step(r, d, ll, lh, in, br);
        #1;
        check("pc_out", pc_out, m_pc);
        check("busy", 16'(busy), 16'(m_fix));
        check("page_cross", 16'(page_cross), 16'(m_fix));
    endtask

    task automatic set_pc(input logic [15:0] v);
        do_cycle(1'b0, v[15:8], 1'b0, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, v[7:0], 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc     = 16'h0000;
        m_target = 16'h0000;
        m_fix    = 1'b0;

        // Reset and byte loads
        do_cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_pc", pc_out, 16'h0000);
        check("reset_busy", 16'(busy), 16'h0000);
        do_cycle(1'b0, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load_lo", pc_out, 16'h0034);
        do_cycle(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        check("load_hi", pc_out, 16'h1234);
        check("load_busy", 16'(busy), 16'h0000);

        // Increment with carry and wrap; load beats inc
        set_pc(16'h12FF);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("inc_carry", pc_out, 16'h1300);
        set_pc(16'hFFFF);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("inc_wrap", pc_out, 16'h0000);
        set_pc(16'h1234);
        do_cycle(1'b0, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
        check("load_wins", pc_out, 16'h12AA);

        // Branches within the page
        set_pc(16'h1234);
        do_cycle(1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        check("br_fwd", pc_out, 16'h1244);
        check("br_fwd_busy", 16'(busy), 16'h0000);
        set_pc(16'h1234);
        do_cycle(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("br_back", pc_out, 16'h1224);
        check("br_back_busy", 16'(busy), 16'h0000);

        // Forward page cross; inc during fixup is ignored
        set_pc(16'h12F0);
        do_cycle(1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fwd_x_mid", pc_out, 16'h126F);
        check("fwd_x_busy", 16'(busy), 16'h0001);
        check("fwd_x_pcross", 16'(page_cross), 16'h0001);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fwd_x_done", pc_out, 16'h136F);
        check("fwd_x_idle", 16'(busy), 16'h0000);

        // Backward page cross and high-byte wrap
        set_pc(16'h1205);
        do_cycle(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("back_x_mid", pc_out, 16'h12F5);
        check("back_x_busy", 16'(busy), 16'h0001);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("back_x_done", pc_out, 16'h11F5);
        set_pc(16'hFFF0);
        do_cycle(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap_x_mid", pc_out, 16'hFF10);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_x_done", pc_out, 16'h0010);
        set_pc(16'h0010);
        do_cycle(1'b0, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap_b_mid", pc_out, 16'h00F0);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_b_done", pc_out, 16'hFFF0);

        // Reset abandons fixup
        set_pc(16'h12F0);
        do_cycle(1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_fix_pc", pc_out, 16'h0000);
        check("rst_fix_busy", 16'(busy), 16'h0000);
        check("rst_fix_pcross", 16'(page_cross), 16'h0000);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_fix_inc", pc_out, 16'h0001);

        // Random commands against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [7:0] d;
            r = ($urandom_range(0, 63) == 0);
            d = 8'($urandom);
            do_cycle(r, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
